// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared types and constants for the multi-object square sprite block:
// the direction encoding carried on objDir, the per-object blink state
// and the colour value that means "nothing drawn here".
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic {
    ALIVE = 1'b0,
    BLINK = 1'b1
  } blink_state_e;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

endpackage

// File: rtl/sprite_channel_ctrl.sv
// sprite_channel_ctrl
// Per-object animation and hit-blink control.
//   clk, resetN   : pixel clock, asynchronous active-low reset
//   startOfFrame  : one-cycle pulse per video frame
//   enable        : object enabled (gates animation only)
//   moving        : object moving (gates animation)
//   hitPulse      : one-cycle hit event, starts/restarts a blink
//   frame         : current animation frame
//   visible       : object currently shown (low during blink off-phases)
//
// state | meaning
// ALIVE | object shown steadily, waiting for a hit
// BLINK | blinkCnt counts frames down, visibility toggles every BLINK_HALF
module sprite_channel_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES   = 2,
  parameter int FRAME_DIV    = 8,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_HALF   = 4,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          startOfFrame,
  input  logic          enable,
  input  logic          moving,
  input  logic          hitPulse,
  output logic [FW-1:0] frame,
  output logic          visible
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int HB = $clog2(BLINK_HALF);

  logic [DW-1:0] div_cnt;
  blink_state_e  state, state_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt <= '0;
      frame   <= '0;
    end else if (startOfFrame && moving && enable) begin
      if (div_cnt == DW'(FRAME_DIV - 1)) begin
        div_cnt <= '0;
        frame   <= (frame == FW'(NUM_FRAMES - 1)) ? '0 : frame + FW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ALIVE;
      blink_cnt <= '0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt_nxt;
    end
  end

  // A hit always takes priority over the frame decrement, so a hit landing
  // on a startOfFrame restarts the full blink rather than losing a frame.
  always_comb begin
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    case (state)
      ALIVE: begin
        if (hitPulse) begin
          state_nxt     = BLINK;
          blink_cnt_nxt = BW'(BLINK_FRAMES);
        end
      end
      BLINK: begin
        if (hitPulse) begin
          blink_cnt_nxt = BW'(BLINK_FRAMES);
        end else if (blink_cnt == '0) begin
          state_nxt = ALIVE;
        end else if (startOfFrame) begin
          blink_cnt_nxt = blink_cnt - BW'(1);
          if (blink_cnt == BW'(1)) state_nxt = ALIVE;
        end
      end
      default: state_nxt = ALIVE;
    endcase
  end

  assign visible = (state == ALIVE) | ~blink_cnt[HB];

endmodule

// File: rtl/multi_sprite_square_object.sv
// multi_sprite_square_object
// Draws up to NUM_OBJ square, rotatable, animated objects. For the current
// pixel it finds the lowest-index object covering it and reports that
// object's rotated bitmap offset, index and animation frame, one cycle later.
//   clk, resetN              : pixel clock, asynchronous active-low reset
//   pixelX, pixelY           : current VGA pixel
//   startOfFrame             : one-cycle pulse per video frame
//   topLeftX, topLeftY       : per-object position
//   objDir                   : per-object direction (up/right/down/left)
//   objEnable, objMoving     : per-object enable and moving flags
//   hitPulse                 : per-object one-cycle hit event
//   offsetX, offsetY         : rotated bitmap offset of the winner
//   objIndex, animFrame      : winner's index and animation frame
//   drawingRequest, RGBout   : draw flag and colour
module multi_sprite_square_object
  import sprite_pkg::*;
#(
  parameter int         NUM_OBJ      = 4,
  parameter int         OBJECT_SIZE  = 25,
  parameter int         NUM_FRAMES   = 2,
  parameter int         FRAME_DIV    = 8,
  parameter int         BLINK_FRAMES = 32,
  parameter int         BLINK_HALF   = 4,
  parameter logic [7:0] OBJECT_COLOR = 8'h5B,
  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [10:0]                   pixelX,
  input  logic [10:0]                   pixelY,
  input  logic                          startOfFrame,
  input  logic [NUM_OBJ-1:0][10:0]      topLeftX,
  input  logic [NUM_OBJ-1:0][10:0]      topLeftY,
  input  logic [NUM_OBJ-1:0][1:0]       objDir,
  input  logic [NUM_OBJ-1:0]            objEnable,
  input  logic [NUM_OBJ-1:0]            objMoving,
  input  logic [NUM_OBJ-1:0]            hitPulse,
  output logic [10:0]                   offsetX,
  output logic [10:0]                   offsetY,
  output logic [IW-1:0]                 objIndex,
  output logic [FW-1:0]                 animFrame,
  output logic                          drawingRequest,
  output logic [7:0]                    RGBout
);

  localparam logic [11:0] SIZE12 = 12'(OBJECT_SIZE);
  localparam logic [10:0] S_MAX  = 11'(OBJECT_SIZE - 1);

  logic [NUM_OBJ-1:0]         visible;
  logic [NUM_OBJ-1:0][FW-1:0] frame;
  logic [NUM_OBJ-1:0]         hit;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : gen_ch
    logic [11:0] x_end, y_end;

    sprite_channel_ctrl #(
      .NUM_FRAMES  (NUM_FRAMES),
      .FRAME_DIV   (FRAME_DIV),
      .BLINK_FRAMES(BLINK_FRAMES),
      .BLINK_HALF  (BLINK_HALF)
    ) u_ch (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .enable      (objEnable[g]),
      .moving      (objMoving[g]),
      .hitPulse    (hitPulse[g]),
      .frame       (frame[g]),
      .visible     (visible[g])
    );

    // 12-bit end coordinates so an object near 2047 cannot wrap to 0.
    assign x_end  = {1'b0, topLeftX[g]} + SIZE12;
    assign y_end  = {1'b0, topLeftY[g]} + SIZE12;
    assign hit[g] = objEnable[g] & visible[g]
                  & (pixelX >= topLeftX[g]) & ({1'b0, pixelX} < x_end)
                  & (pixelY >= topLeftY[g]) & ({1'b0, pixelY} < y_end);
  end

  logic          found;
  logic [IW-1:0] win_idx;
  logic [FW-1:0] win_frame;
  logic [10:0]   dx, dy;
  dir_e          win_dir;
  logic [10:0]   off_x, off_y;

  always_comb begin
    found     = 1'b0;
    win_idx   = '0;
    win_frame = '0;
    dx        = '0;
    dy        = '0;
    win_dir   = DIR_RIGHT;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!found && hit[i]) begin
        found     = 1'b1;
        win_idx   = IW'(i);
        win_frame = frame[i];
        dx        = pixelX - topLeftX[i];
        dy        = pixelY - topLeftY[i];
        win_dir   = dir_e'(objDir[i]);
      end
    end
  end

  always_comb begin
    off_x = '0;
    off_y = '0;
    if (found) begin
      case (win_dir)
        DIR_UP:    begin off_x = S_MAX - dy; off_y = dx;         end
        DIR_RIGHT: begin off_x = dx;         off_y = dy;         end
        DIR_DOWN:  begin off_x = dy;         off_y = S_MAX - dx; end
        DIR_LEFT:  begin off_x = S_MAX - dx; off_y = S_MAX - dy; end
        default:   begin off_x = dx;         off_y = dy;         end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offsetX        <= '0;
      offsetY        <= '0;
      objIndex       <= '0;
      animFrame      <= '0;
      drawingRequest <= 1'b0;
      RGBout         <= TRANSPARENT_ENCODING;
    end else begin
      offsetX        <= off_x;
      offsetY        <= off_y;
      objIndex       <= win_idx;
      animFrame      <= win_frame;
      drawingRequest <= found;
      RGBout         <= found ? OBJECT_COLOR : TRANSPARENT_ENCODING;
    end
  end

endmodule

// File: tb/tb_multi_sprite_square_object.sv
module tb_multi_sprite_square_object;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic [10:0]      pixelX = '0, pixelY = '0;
  logic             startOfFrame = 1'b0;
  logic [3:0][10:0] topLeftX = '0, topLeftY = '0;
  logic [3:0][1:0]  objDir = '0;
  logic [3:0]       objEnable = '0, objMoving = '0, hitPulse = '0;
  logic [10:0]      offsetX, offsetY;
  logic [1:0]       objIndex;
  logic [0:0]       animFrame;
  logic             drawingRequest;
  logic [7:0]       RGBout;

  int total = 0;
  int bad   = 0;

  multi_sprite_square_object dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .objDir(objDir), .objEnable(objEnable), .objMoving(objMoving),
    .hitPulse(hitPulse), .offsetX(offsetX), .offsetY(offsetY),
    .objIndex(objIndex), .animFrame(animFrame),
    .drawingRequest(drawingRequest), .RGBout(RGBout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive at a falling edge, sample at the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic chk_draw(input string tag, input logic dr, input logic [10:0] ox,
                          input logic [10:0] oy, input logic [1:0] idx);
    chk({tag, ".dr"}, 32'(drawingRequest), 32'(dr));
    chk({tag, ".rgb"}, 32'(RGBout), dr ? 32'h5B : 32'hFF);
    chk({tag, ".ox"}, 32'(offsetX), 32'(ox));
    chk({tag, ".oy"}, 32'(offsetY), 32'(oy));
    chk({tag, ".idx"}, 32'(objIndex), 32'(idx));
  endtask

  initial begin
    // reset values
    step();
    chk_draw("reset", 1'b0, 11'd0, 11'd0, 2'd0);
    chk("reset.frame", 32'(animFrame), 32'd0);
    resetN = 1'b1;

    // obj0 at (100,100), rotations
    topLeftX[0] = 11'd100; topLeftY[0] = 11'd100; objEnable[0] = 1'b1;
    pixelX = 11'd110; pixelY = 11'd105;
    objDir[0] = 2'd1; step(); chk_draw("right", 1'b1, 11'd10, 11'd5, 2'd0);
    objDir[0] = 2'd0; step(); chk_draw("up",    1'b1, 11'd19, 11'd10, 2'd0);
    objDir[0] = 2'd2; step(); chk_draw("down",  1'b1, 11'd5, 11'd14, 2'd0);
    objDir[0] = 2'd3; step(); chk_draw("left",  1'b1, 11'd14, 11'd19, 2'd0);
    objDir[0] = 2'd1;
    pixelX = 11'd125; pixelY = 11'd100; step(); chk_draw("xend", 1'b0, 11'd0, 11'd0, 2'd0);
    pixelX = 11'd124; pixelY = 11'd124; step(); chk_draw("corner", 1'b1, 11'd24, 11'd24, 2'd0);
    pixelX = 11'd99;  pixelY = 11'd100; step(); chk_draw("xbefore", 1'b0, 11'd0, 11'd0, 2'd0);
    pixelX = 11'd110; pixelY = 11'd125; step(); chk_draw("yend", 1'b0, 11'd0, 11'd0, 2'd0);

    // overlapping objects, priority
    topLeftX[1] = 11'd200; topLeftY[1] = 11'd200; objDir[1] = 2'd1;
    topLeftX[2] = 11'd200; topLeftY[2] = 11'd200; objDir[2] = 2'd1;
    objEnable[2:1] = 2'b11;
    pixelX = 11'd205; pixelY = 11'd205; step(); chk_draw("prio1", 1'b1, 11'd5, 11'd5, 2'd1);
    objEnable[1] = 1'b0; step(); chk_draw("prio2", 1'b1, 11'd5, 11'd5, 2'd2);

    // animation of obj0
    pixelX = 11'd110; pixelY = 11'd105; objMoving[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      sof_pulse();
      if (k == 7)  chk("anim.p7",  32'(animFrame), 32'd0);
      if (k == 8)  chk("anim.p8",  32'(animFrame), 32'd1);
      if (k == 15) chk("anim.p15", 32'(animFrame), 32'd1);
      if (k == 16) chk("anim.p16", 32'(animFrame), 32'd0);
    end
    for (int k = 0; k < 8; k++) sof_pulse();
    chk("anim.p24", 32'(animFrame), 32'd1);
    objMoving[0] = 1'b0;
    for (int k = 0; k < 8; k++) sof_pulse();
    chk("anim.hold", 32'(animFrame), 32'd1);
    objMoving[0] = 1'b1; objEnable[0] = 1'b0;
    for (int k = 0; k < 8; k++) sof_pulse();
    objEnable[0] = 1'b1; objMoving[0] = 1'b0; step();
    chk("anim.dis_hold", 32'(animFrame), 32'd1);

    // blink: hidden for pulses 1-4, 9-12, 17-20, 25-28
    hitPulse[0] = 1'b1; step(); hitPulse[0] = 1'b0; step();
    chk("blink.start", 32'(drawingRequest), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      sof_pulse();
      chk($sformatf("blink.k%0d", k), 32'(drawingRequest),
          (((k - 1) / 4) % 2 == 0) ? 32'd0 : 32'd1);
    end
    for (int k = 1; k <= 4; k++) begin
      sof_pulse();
      chk("blink.alive", 32'(drawingRequest), 32'd1);
    end

    // restart: hit coinciding with pulse 10 reloads the full count
    hitPulse[0] = 1'b1; step(); hitPulse[0] = 1'b0; step();
    for (int k = 1; k <= 9; k++) sof_pulse();
    chk("restart.p9", 32'(drawingRequest), 32'd0);
    hitPulse[0] = 1'b1; startOfFrame = 1'b1; step();
    hitPulse[0] = 1'b0; startOfFrame = 1'b0; step();
    chk("restart.p10", 32'(drawingRequest), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      sof_pulse();
      chk($sformatf("restart.k%0d", k), 32'(drawingRequest),
          (((k - 1) / 4) % 2 == 0) ? 32'd0 : 32'd1);
    end

    // no wrap-around near 2047
    topLeftX[3] = 11'd2040; topLeftY[3] = 11'd2040; objDir[3] = 2'd1; objEnable[3] = 1'b1;
    pixelX = 11'd5; pixelY = 11'd5; step(); chk_draw("wrap", 1'b0, 11'd0, 11'd0, 2'd0);
    pixelX = 11'd2047; pixelY = 11'd2047; step(); chk_draw("edge", 1'b1, 11'd7, 11'd7, 2'd3);

    // reset mid-blink, in a visible phase, with frame 1
    pixelX = 11'd110; pixelY = 11'd105;
    hitPulse[0] = 1'b1; step(); hitPulse[0] = 1'b0; step();
    for (int k = 1; k <= 5; k++) sof_pulse();
    chk("rst.pre_dr", 32'(drawingRequest), 32'd1);
    chk("rst.pre_frame", 32'(animFrame), 32'd1);
    @(posedge clk); #2;
    resetN = 1'b0; #1;
    chk_draw("rst.async", 1'b0, 11'd0, 11'd0, 2'd0);
    step(); resetN = 1'b1;
    step();
    chk_draw("rst.after", 1'b1, 11'd10, 11'd5, 2'd0);
    chk("rst.frame", 32'(animFrame), 32'd0);
    sof_pulse();
    chk("rst.alive", 32'(drawingRequest), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
